// File: rtl/masked_and_initiator_if.sv
// Gadget-side bus of the masked AND initiator.
// master: the initiator drives the input shares, the refresh random and AndEnable.
// slave:  the AND2 gadget returns AndDone and its two output shares.
//   and_ina[1:0]  shares of the current A bit ([0]=a^ma, [1]=ma)
//   and_inb[1:0]  shares of the current B bit ([0]=b^mb, [1]=mb)
//   and_rin       gadget refresh random r
//   AndEnable     gadget enable
//   AndDone       gadget completion flag
//   and_out[1:0]  gadget output shares
interface masked_and_initiator_if;
  logic [1:0] and_ina;
  logic [1:0] and_inb;
  logic       and_rin;
  logic       AndEnable;
  logic       AndDone;
  logic [1:0] and_out;

  modport master (
    output and_ina,
    output and_inb,
    output and_rin,
    output AndEnable,
    input  AndDone,
    input  and_out
  );

  modport slave (
    input  and_ina,
    input  and_inb,
    input  and_rin,
    input  AndEnable,
    output AndDone,
    output and_out
  );
endinterface

// File: rtl/masked_and_initiator.sv
// Initiator for one 2-share masked AND2 gadget.
// Splits each operand bit into two Boolean shares with fresh randomness, runs the gadget one
// bit at a time (LSB first) and collects its output shares. Shares are never recombined here.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           pulse to latch a/b and begin (only accepted when idle)
//   a, b            plaintext operands, WIDTH bits
//   rnd_in          fresh random {ma, mb, r}, sampled while rnd_req=1
//   rnd_req         high in the encode cycle only
//   gad             gadget bus (master side)
//   res_s0, res_s1  result shares, res_s0 ^ res_s1 == a & b
//   busy            high outside idle
//   done            one-cycle success pulse
//   err             sticky gadget timeout, cleared by the next accepted start
module masked_and_initiator #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic [2:0]             rnd_in,
  output logic                   rnd_req,
  masked_and_initiator_if.master gad,
  output logic [WIDTH-1:0]       res_s0,
  output logic [WIDTH-1:0]       res_s1,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StEnc, StRun, StNext, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        ina_q, ina_d;
  logic [1:0]        inb_q, inb_d;
  logic              rin_q, rin_d;
  logic              en_q, en_d;
  logic [WIDTH-1:0]  res0_q, res0_d;
  logic [WIDTH-1:0]  res1_q, res1_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ina_q   <= '0;
      inb_q   <= '0;
      rin_q   <= 1'b0;
      en_q    <= 1'b0;
      res0_q  <= '0;
      res1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ina_q   <= ina_d;
      inb_q   <= inb_d;
      rin_q   <= rin_d;
      en_q    <= en_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ina_d   = ina_q;
    inb_d   = inb_q;
    rin_d   = rin_q;
    en_d    = en_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    err_d   = err_q;
    rnd_req = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          err_d   = 1'b0;
          res0_d  = '0;
          res1_d  = '0;
          state_d = StEnc;
        end
      end
      StEnc: begin
        // Only the masked bit and the mask leave the block, never the plain bit.
        rnd_req = 1'b1;
        ina_d   = {rnd_in[2], a_q[idx_q] ^ rnd_in[2]};
        inb_d   = {rnd_in[1], b_q[idx_q] ^ rnd_in[1]};
        rin_d   = rnd_in[0];
        en_d    = 1'b1;
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // AndDone in the first RUN cycle can be left over from the previous bit.
        if (cnt_q != '0 && gad.AndDone) begin
          res0_d[idx_q] = gad.and_out[0];
          res1_d[idx_q] = gad.and_out[1];
          en_d          = 1'b0;
          state_d       = StNext;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = StErr;
        end
      end
      StNext: begin
        if (idx_q == IdxW'(WIDTH - 1)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StEnc;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StErr: begin
        // A partial result is useless after a timeout; clear it.
        res0_d  = '0;
        res1_d  = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign gad.and_ina   = ina_q;
  assign gad.and_inb   = inb_q;
  assign gad.and_rin   = rin_q;
  assign gad.AndEnable = en_q;

  assign res_s0 = res0_q;
  assign res_s1 = res1_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign err    = err_q;

endmodule

// File: tb/tb_masked_and_initiator.sv
// Bench for masked_and_initiator: behavioural gadget, cycle-offset reference model, directed
// cases with literal expectations followed by randomized operations.
module tb_masked_and_initiator;
  localparam int W  = 4;
  localparam int TO = 8;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         start  = 1'b0;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic [2:0]   rnd_in = 3'b000;
  logic         rnd_req;
  logic [W-1:0] res_s0;
  logic [W-1:0] res_s1;
  logic         busy;
  logic         done;
  logic         err;

  masked_and_initiator_if gif ();

  masked_and_initiator #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .rnd_in  (rnd_in),
    .rnd_req (rnd_req),
    .gad     (gif.master),
    .res_s0  (res_s0),
    .res_s1  (res_s1),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gadget: mode 0 raises AndDone on its k-th enabled edge, 1 holds AndDone high, 2 never.
  int   g_mode = 0;
  int   g_k    = 3;
  int   g_cnt  = 0;
  logic g_done = 1'b0;

  always @(posedge clk) begin
    if (gif.AndEnable !== 1'b1) begin
      g_cnt  <= 0;
      g_done <= 1'b0;
    end else begin
      g_cnt <= g_cnt + 1;
      if (g_cnt + 1 >= g_k) g_done <= 1'b1;
    end
  end

  assign gif.AndDone    = (g_mode == 1) ? 1'b1 : (g_mode == 2) ? 1'b0 : g_done;
  assign gif.and_out[0] = (gif.and_ina[0] & gif.and_inb[0]) ^ (gif.and_ina[0] & gif.and_inb[1])
                          ^ gif.and_rin;
  assign gif.and_out[1] = (gif.and_ina[1] & gif.and_inb[1]) ^ (gif.and_ina[1] & gif.and_inb[0])
                          ^ gif.and_rin;

  // Randomness source: random, or 000/111 alternating per encode cycle.
  bit alt_mode = 1'b0;
  bit alt_bit  = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_in = alt_mode ? {3{alt_bit}} : 3'($urandom);
      if (alt_mode && rnd_req === 1'b1) alt_bit = ~alt_bit;
    end
  end

  // Reference model: an accepted op occupies offsets 0..m_last after its start edge.
  // Per bit: 1 encode cycle, m_R gadget cycles, 1 step cycle; then one done/err cycle.
  int           cyc        = 0;
  bit           m_act      = 1'b0;
  int           m_t0       = 0;
  int           m_R        = 4;
  int           m_last     = 0;
  bit           m_fail     = 1'b0;
  bit           m_err      = 1'b0;
  bit           m_res_zero = 1'b1;
  logic [W-1:0] m_a        = '0;
  logic [W-1:0] m_b        = '0;
  logic [W-1:0] m_xor      = '0;
  logic [2:0]   enc_rnd [W];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_act      = 1'b0;
        m_err      = 1'b0;
        m_res_zero = 1'b1;
      end else begin
        int o;
        bit mb;
        o  = cyc - m_t0;
        mb = m_act && (o <= m_last);
        if (mb && o != m_last && (o % (m_R + 2)) == 0) enc_rnd[o / (m_R + 2)] = rnd_in;
        if (mb && o == m_last) begin
          m_act = 1'b0;
          if (m_fail) begin
            m_res_zero = 1'b1;
          end else begin
            m_res_zero = 1'b0;
            m_xor      = m_a & m_b;
          end
        end
        if (m_act && m_fail && (o + 1) == m_last) m_err = 1'b1;
        if (start === 1'b1 && !mb) begin
          m_act      = 1'b1;
          m_t0       = cyc + 1;
          m_a        = a;
          m_b        = b;
          m_err      = 1'b0;
          m_res_zero = 1'b1;
          if (g_mode == 1) begin
            m_R    = 2;
            m_fail = 1'b0;
          end else if (g_mode == 0 && g_k + 1 <= TO) begin
            m_R    = g_k + 1;
            m_fail = 1'b0;
          end else begin
            m_R    = TO;
            m_fail = 1'b1;
          end
          m_last = m_fail ? TO + 1 : W * (m_R + 2);
        end
        cyc = cyc + 1;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        int o, j, p;
        bit mb, e_done, e_req, e_en, e_hold;
        o      = cyc - m_t0;
        mb     = m_act && (o <= m_last);
        p      = o % (m_R + 2);
        j      = o / (m_R + 2);
        e_done = mb && !m_fail && o == m_last;
        e_req  = mb && o != m_last && p == 0;
        e_en   = mb && o != m_last && p >= 1 && p <= m_R;
        e_hold = mb && o != m_last && p >= 1;
        chk("busy", 32'(busy), 32'(mb));
        chk("done", 32'(done), 32'(e_done));
        chk("rnd_req", 32'(rnd_req), 32'(e_req));
        chk("and_enable", 32'(gif.AndEnable), 32'(e_en));
        chk("err", 32'(err), 32'(m_err));
        if (e_hold) begin
          chk("and_ina", 32'(gif.and_ina), 32'({enc_rnd[j][2], m_a[j] ^ enc_rnd[j][2]}));
          chk("and_inb", 32'(gif.and_inb), 32'({enc_rnd[j][1], m_b[j] ^ enc_rnd[j][1]}));
          chk("and_rin", 32'(gif.and_rin), 32'(enc_rnd[j][0]));
        end
        if (e_done) chk("res_xor_done", 32'(res_s0 ^ res_s1), 32'(m_a & m_b));
        if (!mb) begin
          if (m_res_zero) begin
            chk("res_s0_idle", 32'(res_s0), 32'(0));
            chk("res_s1_idle", 32'(res_s1), 32'(0));
          end else begin
            chk("res_xor_idle", 32'(res_s0 ^ res_s1), 32'(m_xor));
          end
        end
      end
    end
  end

  // Start one op and follow it until idle; offsets are cycles after the start edge.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input int mode,
                        input int k, input bit alt, input bit noise,
                        output int lat, output int eo, output int nreq);
    int o;
    g_mode   = mode;
    g_k      = k;
    alt_mode = alt;
    alt_bit  = 1'b0;
    a        = ia;
    b        = ib;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    eo    = -1;
    nreq  = 0;
    o     = 0;
    while (busy === 1'b1 && o < 400) begin
      if (rnd_req === 1'b1) nreq++;
      if (done === 1'b1 && lat < 0) lat = o;
      if (err === 1'b1 && eo < 0) eo = o;
      if (noise && (o % 7) == 3) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      o++;
    end
    start = 1'b0;
    chk("op_bound", 32'(busy), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, eo, nreq;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_res_s0", 32'(res_s0), 32'(0));
    chk("rst_res_s1", 32'(res_s1), 32'(0));
    chk("rst_enable", 32'(gif.AndEnable), 32'(0));
    chk("rst_rnd_req", 32'(rnd_req), 32'(0));
    chk("rst_ina", 32'(gif.and_ina), 32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Compliant gadget: 6 cycles per bit.
    run_op(4'hB, 4'h6, 0, 3, 1'b0, 1'b0, lat, eo, nreq);
    chk("t1_latency", lat, 24);
    chk("t1_rnd_req_count", nreq, 4);
    chk("t1_xor", 32'(res_s0 ^ res_s1), 32'h2);

    run_op(4'hF, 4'hF, 0, 3, 1'b1, 1'b0, lat, eo, nreq);
    chk("t2_latency", lat, 24);
    chk("t2_xor", 32'(res_s0 ^ res_s1), 32'hF);

    // AndDone stuck high: ignored at cnt==0, captured at cnt==1.
    run_op(4'hD, 4'hB, 1, 3, 1'b0, 1'b0, lat, eo, nreq);
    chk("t3_latency", lat, 16);
    chk("t3_xor", 32'(res_s0 ^ res_s1), 32'h9);

    // Gadget never answers.
    run_op(4'h7, 4'h7, 2, 3, 1'b0, 1'b0, lat, eo, nreq);
    chk("t4_err_offset", eo, 9);
    chk("t4_no_done", lat, -1);
    chk("t4_err", 32'(err), 32'(1));
    chk("t4_res_s0", 32'(res_s0), 32'(0));
    chk("t4_res_s1", 32'(res_s1), 32'(0));
    chk("t4_enable", 32'(gif.AndEnable), 32'(0));
    run_op(4'h3, 4'h5, 0, 3, 1'b0, 1'b0, lat, eo, nreq);
    chk("t4_err_cleared", 32'(err), 32'(0));
    chk("t4_next_xor", 32'(res_s0 ^ res_s1), 32'h1);

    // Timeout boundary: answer in the last RUN cycle succeeds, one later fails.
    run_op(4'hA, 4'hC, 0, 7, 1'b0, 1'b0, lat, eo, nreq);
    chk("tb_k7_latency", lat, 40);
    chk("tb_k7_xor", 32'(res_s0 ^ res_s1), 32'h8);
    run_op(4'hA, 4'hC, 0, 8, 1'b0, 1'b0, lat, eo, nreq);
    chk("tb_k8_err_offset", eo, 9);
    run_op(4'h9, 4'hF, 0, 1, 1'b0, 1'b0, lat, eo, nreq);
    chk("tb_k1_latency", lat, 16);
    chk("tb_k1_xor", 32'(res_s0 ^ res_s1), 32'h9);

    // Reset during RUN of bit 2.
    g_mode   = 0;
    g_k      = 3;
    alt_mode = 1'b0;
    a        = 4'hE;
    b        = 4'h7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    chk("t5_enable_before", 32'(gif.AndEnable), 32'(1));
    rst = 1'b1;
    #1;
    chk("t5_enable", 32'(gif.AndEnable), 32'(0));
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_res_s0", 32'(res_s0), 32'(0));
    chk("t5_res_s1", 32'(res_s1), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(4'hE, 4'h7, 0, 3, 1'b0, 1'b0, lat, eo, nreq);
    chk("t5_latency", lat, 24);
    chk("t5_xor", 32'(res_s0 ^ res_s1), 32'h6);

    // Starts while busy must be ignored.
    run_op(4'h6, 4'h3, 0, 3, 1'b0, 1'b1, lat, eo, nreq);
    chk("t6_latency", lat, 24);
    chk("t6_xor", 32'(res_s0 ^ res_s1), 32'h2);

    for (int i = 0; i < 40; i++) begin
      int sel, kk, gap;
      sel = $urandom_range(0, 9);
      kk  = $urandom_range(1, 9);
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      run_op(W'($urandom), W'($urandom), (sel < 7) ? 0 : ((sel < 9) ? 1 : 2), kk,
             1'($urandom), 1'($urandom), lat, eo, nreq);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
